// File: rtl/dram_bank_array.sv
// dram_bank_array: multi-bank DRAM timing model.
// Each bank tracks an open flag, the open row and a busy counter that enforces
// tRCD after ACTIVATE and tRP after PRECHARGE. READs go through a fixed
// T_CL-cycle pipeline. Illegal commands are consumed and flagged on err.
// Optional periodic refresh is enabled by defining DRAM_REFRESH_EN.

// Per-bank state: open flag, open row and busy counter.
module dram_bank_state #(
    parameter int ROW_W = 7,
    parameter int T_RCD = 2,
    parameter int T_RP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act,
    input  logic             pre,
    input  logic             close_all,
    input  logic [ROW_W-1:0] row_in,
    output logic             is_open,
    output logic [ROW_W-1:0] open_row,
    output logic             idle
);
    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W = $clog2(T_MAX) + 1;

    logic             open_q, open_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next bank state: count down, then apply ACTIVATE/PRECHARGE/refresh close.
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        cnt_d  = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        if (act) begin
            open_d = 1'b1;
            row_d  = row_in;
            cnt_d  = CNT_W'(T_RCD - 1);
        end else if (pre) begin
            open_d = 1'b0;
            cnt_d  = CNT_W'(T_RP - 1);
        end
        if (close_all) begin
            open_d = 1'b0;
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= 1'b0;
            row_q  <= '0;
            cnt_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            cnt_q  <= cnt_d;
        end
    end

    assign is_open  = open_q;
    assign open_row = row_q;
    assign idle     = (cnt_q == '0);
endmodule

module dram_bank_array #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_CL         = 2,
    parameter int T_REFI       = 64,
    parameter int T_RFC        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  col_id,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            err,
    output logic                            refresh_busy
);
    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int DEPTH  = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] CMD_RD  = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_ACT = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    // Reject nonsensical timing at elaboration.
    if (T_RCD < 1 || T_RP < 1 || T_CL < 1 || T_REFI < 2 || T_RFC < 1) begin : g_param_check
        $error("dram_bank_array: timing parameter out of range");
    end

    logic [NUM_OF_BANKS-1:0]            bank_open;
    logic [NUM_OF_BANKS-1:0][ROW_W-1:0] bank_row;
    logic [NUM_OF_BANKS-1:0]            bank_idle;
    logic [NUM_OF_BANKS-1:0]            act_vec;
    logic [NUM_OF_BANKS-1:0]            pre_vec;

    logic                  ref_block;   // refresh pending or running: hold off commands
    logic                  ref_close;   // refresh running: force all banks closed
    logic                  sel_open;
    logic [ROW_W-1:0]      sel_row;
    logic                  sel_idle;
    logic                  accept;
    logic                  legal;
    logic                  cmd_ok;
    logic                  wr_en;
    logic                  rd_fire;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  err_q, err_d;

    logic [T_CL:0]                 vld_pipe_q, vld_pipe_d;
    logic [T_CL:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

    // Array storage; deliberately left unreset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
        dram_bank_state #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .act       (act_vec[b]),
            .pre       (pre_vec[b]),
            .close_all (ref_close),
            .row_in    (row_id),
            .is_open   (bank_open[b]),
            .open_row  (bank_row[b]),
            .idle      (bank_idle[b])
        );
    end

    // Command decode: readiness, legality and per-bank strobes.
    always_comb begin
        sel_open  = bank_open[bank_id];
        sel_row   = bank_row[bank_id];
        sel_idle  = bank_idle[bank_id];
        cmd_ready = sel_idle && !ref_block;
        accept    = cmd_valid && cmd_ready;
        legal     = (cmd == CMD_ACT) ? !sel_open : sel_open;
        cmd_ok    = accept && legal;
        wr_en     = cmd_ok && (cmd == CMD_WR);
        rd_fire   = cmd_ok && (cmd == CMD_RD);
        err_d     = accept && !legal;
        mem_addr  = ADDR_W'((int'(bank_id) * NUM_OF_ROWS + int'(sel_row)) * NUM_OF_COLS
                            + int'(col_id));
        rd_word   = mem_q[mem_addr];
        act_vec   = '0;
        pre_vec   = '0;
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
            act_vec[b] = cmd_ok && (cmd == CMD_ACT) && (bank_id == BANK_W'(b));
            pre_vec[b] = cmd_ok && (cmd == CMD_PRE) && (bank_id == BANK_W'(b));
        end
    end

    // Read pipeline shift: stage 0 captures at the accepting edge.
    always_comb begin
        vld_pipe_d    = {vld_pipe_q[T_CL-1:0], rd_fire};
        dat_pipe_d    = dat_pipe_q;
        dat_pipe_d[0] = rd_fire ? rd_word : '0;
        for (int i = 1; i <= T_CL; i++) begin
            dat_pipe_d[i] = dat_pipe_q[i-1];
        end
    end

    // Pipeline and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
            err_q      <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
            err_q      <= err_d;
        end
    end

    // Array write on the accepting edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[mem_addr] <= wr_data;
        end
    end

    assign rd_valid = vld_pipe_q[T_CL];
    assign rd_data  = dat_pipe_q[T_CL];
    assign err      = err_q;

`ifdef DRAM_REFRESH_EN
    typedef enum logic [1:0] {
        REF_IDLE = 2'd0,
        REF_PEND = 2'd1,
        REF_RUN  = 2'd2
    } ref_state_e;

    localparam int IVL_W = $clog2(T_REFI);
    localparam int RFC_W = $clog2(T_RFC) + 1;

    ref_state_e       ref_state_q, ref_state_d;
    logic [IVL_W-1:0] ivl_q, ivl_d;
    logic [RFC_W-1:0] rfc_q, rfc_d;

    // Refresh FSM: interval count, drain bank timers, then refresh for T_RFC cycles.
    always_comb begin
        ref_state_d = ref_state_q;
        ivl_d       = ivl_q;
        rfc_d       = rfc_q;
        case (ref_state_q)
            REF_IDLE: begin
                if (ivl_q == IVL_W'(T_REFI - 1)) begin
                    ref_state_d = REF_PEND;
                    ivl_d       = '0;
                end else begin
                    ivl_d = ivl_q + 1'b1;
                end
            end
            REF_PEND: begin
                if (&bank_idle) begin
                    ref_state_d = REF_RUN;
                    rfc_d       = RFC_W'(T_RFC - 1);
                end
            end
            REF_RUN: begin
                if (rfc_q == '0) begin
                    ref_state_d = REF_IDLE;
                    ivl_d       = '0;
                end else begin
                    rfc_d = rfc_q - 1'b1;
                end
            end
            default: ref_state_d = REF_IDLE;
        endcase
    end

    // Refresh state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_state_q <= REF_IDLE;
            ivl_q       <= '0;
            rfc_q       <= '0;
        end else begin
            ref_state_q <= ref_state_d;
            ivl_q       <= ivl_d;
            rfc_q       <= rfc_d;
        end
    end

    assign ref_block    = (ref_state_q != REF_IDLE);
    assign ref_close    = (ref_state_q == REF_RUN);
    assign refresh_busy = ref_close;
`else
    assign ref_block    = 1'b0;
    assign ref_close    = 1'b0;
    assign refresh_busy = 1'b0;
`endif
endmodule

// File: doc/dram_bank_array.md
# dram_bank_array

Parametrised, synthesizable multi-bank DRAM model with per-bank row buffers, activate/precharge timing counters, a fixed-latency read pipeline, and optional periodic refresh. It sits below the DRAM controller in place of the single-bit, untimed bank model. It gives controller benches realistic per-bank busy windows, CAS latency and illegal-command detection at configurable data width.

## Interface
Parameters:
- NUM_OF_BANKS, 8, number of banks; bank_id width is clog2
- NUM_OF_ROWS, 128, rows per bank; row_id width is clog2
- NUM_OF_COLS, 8, columns per row; col_id width is clog2
- DATA_WIDTH, 8, bits per column
- T_RCD, 2, cycles from ACTIVATE to next command on same bank (≥1)
- T_RP, 2, cycles from PRECHARGE to next command on same bank (≥1)
- T_CL, 2, read latency in cycles (≥1)
- T_REFI, 64, refresh interval in cycles (refresh build only)
- T_RFC, 4, refresh busy duration in cycles (refresh build only)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on this edge if cmd_valid
- cmd  in  2  00 READ, 01 WRITE, 10 ACTIVATE, 11 PRECHARGE
- bank_id  in  clog2(NUM_OF_BANKS)  target bank
- row_id  in  clog2(NUM_OF_ROWS)  row; ACTIVATE only
- col_id  in  clog2(NUM_OF_COLS)  column; READ/WRITE only
- wr_data  in  DATA_WIDTH  WRITE data
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  DATA_WIDTH  read data
- err  out  1  one-cycle pulse: illegal command accepted
- refresh_busy  out  1  refresh in progress

## Operation
- Per bank: open flag, open row register, busy counter. Array storage is not reset.
- cmd_ready is combinational: busy counter of addressed bank is zero and no refresh is pending or active.
- ACTIVATE, bank closed: open flag = 1, open row = row_id, counter loaded with T_RCD-1.
- PRECHARGE, bank open: open flag = 0, counter loaded with T_RP-1.
- WRITE, bank open: array[bank][open row][col_id] = wr_data at the accepting edge.
- READ, bank open: the array word enters the read pipeline.
- Illegal commands are ACTIVATE to an open bank, or READ/WRITE/PRECHARGE to a closed bank.
  - They are still consumed and leave state unchanged.
  - err pulses high in the following cycle.
  - An illegal READ produces no rd_valid.
- Banks are fully independent. A command to bank A never stalls on bank B's counter.
- Read pipeline: T_CL-stage shift register of {valid, data}. One read is accepted per cycle; responses return in order with no bubbles.

## Timing
- Reset values: cmd_ready=1, rd_valid=0, rd_data=0, err=0, refresh_busy=0, all banks closed, all counters 0, pipeline empty.
- READ accepted at edge E returns rd_valid/rd_data registered at edge E+T_CL, for exactly one cycle.
- ACTIVATE accepted at edge E: the next same-bank command is accepted no earlier than edge E+T_RCD.
- PRECHARGE accepted at edge E: the next same-bank command is accepted no earlier than edge E+T_RP.
- WRITE then READ to the same address on consecutive edges returns the new data.
- Reset mid-operation clears the pipeline, counters, open flags and refresh state immediately. In-flight reads are dropped.

## Configuration
- DRAM_REFRESH_EN defined:
  - Interval counter runs from reset.
  - FSM states:
    - IDLE → PENDING when the counter reaches T_REFI-1.
    - PENDING holds cmd_ready=0. It moves to REFRESH when all bank counters are zero; in-flight reads still complete.
    - REFRESH closes all banks and drives refresh_busy=1 for T_RFC cycles, then returns to IDLE and restarts the interval counter.
- DRAM_REFRESH_EN undefined:
  - No interval counter or FSM.
  - refresh_busy is tied to 0.
  - cmd_ready depends only on bank counters.

## Test plan
- Reset: hold rst 3 cycles → cmd_ready=1, rd_valid=0, err=0, refresh_busy=0.
- ACT bank 3 row 5, WRITE col 2 0xA5 at earliest legal edge (E+2), READ col 2 next edge → rd_valid=1 with rd_data=0xA5 exactly 2 edges after READ.
- READ bank 1 while it is closed → err pulses for one cycle, no rd_valid, bank 1 stays closed.
- ACT bank 0 row 1 and ACT bank 1 row 2 on consecutive edges, both accepted. Four back-to-back READs alternating banks → four consecutive rd_valid cycles in issue order.
- PRE bank 3 → cmd_ready for bank 3 is low for 1 cycle. A subsequent READ bank 3 gives err. Re-ACT row 5 and READ col 2 → 0xA5 retained.
- With DRAM_REFRESH_EN, idle 64 cycles → cmd_ready falls, refresh_busy high for 4 cycles, a READ afterwards gives err (banks closed). Asserting rst during refresh → refresh_busy=0 on the same cycle.
